// File: rtl/buf_occupancy_tracker.sv
// Front-end buffer occupancy tracker: decodes per-board serial clear streams and
// counts triggers minus clears per FPGA. Optional running peak of NFull under BUFOCC_PEAK_EN.
module buf_occupancy_tracker #(
  parameter int              NCH       = 8,
  parameter int              DEPTH     = 4,
  parameter logic [NCH-1:0]  DUAL_MASK = 8'hF0,
  parameter int              ERRW      = 16,
  localparam int             CW        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      mask,
  input  logic [NCH-1:0]      undo_buf,
  input  logic                trigger,
  input  logic                err_clr,
  output logic [2*NCH-1:0]    buf_clr,
  output logic [2*NCH-1:0]    blip,
  output logic                trig_ok,
  output logic [CW-1:0]       n_full,
  output logic [ERRW-1:0]     n_err,
  output logic [NCH-1:0]      err_flags
`ifdef BUFOCC_PEAK_EN
  ,
  output logic [CW-1:0]       peak_full
`endif
);

  typedef enum logic [3:0] {
    ST_WAIT = 4'b0001,
    ST_SCND = 4'b0010,
    ST_THRD = 4'b0100,
    ST_PAUS = 4'b1000
  } state_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t           state [NCH];
  logic [NCH-1:0]   bit2;
  logic [CW-1:0]    cnt [NCH][2];
  logic [CW-1:0]    cnt_nxt [NCH][2];
  logic [NCH-1:0]   clr_even, clr_odd, bad_code, ch_err;
  logic [2*NCH-1:0] blip_q, blip_nxt, mask_x;

  // Code evaluation happens only in the third frame slot of an enabled channel.
  always_comb begin
    logic [1:0] code;
    code     = 2'b00;
    clr_even = '0;
    clr_odd  = '0;
    bad_code = '0;
    for (int i = 0; i < NCH; i++) begin
      code = {bit2[i], undo_buf[i]};
      if (mask[i] && state[i] == ST_THRD) begin
        if (code == 2'b10)
          clr_even[i] = 1'b1;
        else if (DUAL_MASK[i] && code == 2'b01)
          clr_odd[i] = 1'b1;
        else
          bad_code[i] = 1'b1;
      end
    end
  end

  // A trigger and a clear on the same FPGA cancel; the odd counter of a single board stays 0.
  always_comb begin
    logic inc, dec;
    inc      = 1'b0;
    dec      = 1'b0;
    ch_err   = bad_code;
    blip_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int f = 0; f < 2; f++) begin
        cnt_nxt[i][f] = cnt[i][f];
        inc = trigger;
        dec = (f == 0) ? clr_even[i] : clr_odd[i];
        if (!mask[i] || (f == 1 && !DUAL_MASK[i])) begin
          cnt_nxt[i][f] = '0;
        end else if (inc && !dec) begin
          if (cnt[i][f] == FULL)
            ch_err[i] = 1'b1;
          else
            cnt_nxt[i][f] = cnt[i][f] + 1'b1;
        end else if (dec && !inc) begin
          if (cnt[i][f] == '0)
            ch_err[i] = 1'b1;
          else
            cnt_nxt[i][f] = cnt[i][f] - 1'b1;
        end
      end
      blip_nxt[2*i]   = clr_even[i];
      blip_nxt[2*i+1] = DUAL_MASK[i] ? clr_odd[i] : clr_even[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]  <= ST_WAIT;
        cnt[i][0] <= '0;
        cnt[i][1] <= '0;
      end
      bit2   <= '0;
      blip_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i][0] <= cnt_nxt[i][0];
        cnt[i][1] <= cnt_nxt[i][1];
        if (!mask[i]) begin
          state[i] <= ST_WAIT;
        end else begin
          unique case (state[i])
            ST_WAIT: if (undo_buf[i]) state[i] <= ST_SCND;
            ST_SCND: begin
              bit2[i]  <= undo_buf[i];
              state[i] <= ST_THRD;
            end
            ST_THRD: state[i] <= ST_PAUS;
            ST_PAUS: state[i] <= ST_WAIT;
            default: state[i] <= ST_WAIT;
          endcase
        end
      end
      blip_q <= blip_nxt;
    end
  end

  // err_clr takes priority over errors raised in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flags <= '0;
      n_err     <= '0;
    end else if (err_clr) begin
      err_flags <= '0;
      n_err     <= '0;
    end else begin
      err_flags <= err_flags | ch_err;
      if (|ch_err && n_err != '1)
        n_err <= n_err + 1'b1;
    end
  end

  always_comb begin
    n_full  = '0;
    buf_clr = '0;
    mask_x  = '0;
    for (int i = 0; i < NCH; i++) begin
      mask_x[2*i]     = mask[i];
      mask_x[2*i+1]   = mask[i];
      buf_clr[2*i]    = !mask[i] || (cnt[i][0] < FULL);
      buf_clr[2*i+1]  = DUAL_MASK[i] ? (!mask[i] || (cnt[i][1] < FULL)) : buf_clr[2*i];
      for (int f = 0; f < 2; f++) begin
        if (mask[i] && cnt[i][f] > n_full)
          n_full = cnt[i][f];
      end
    end
    trig_ok = &(buf_clr | ~mask_x);
  end

  assign blip = blip_q;

`ifdef BUFOCC_PEAK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      peak_full <= '0;
    else if (err_clr)
      peak_full <= '0;
    else if (n_full > peak_full)
      peak_full <= n_full;
  end
`endif

endmodule

// File: tb/tb_buf_occupancy_tracker.sv
// Self-checking bench for buf_occupancy_tracker: directed scenarios with literal
// expectations, then randomized traffic against a cycle-offset reference model.
module tb_buf_occupancy_tracker;

  localparam int             NCH   = 8;
  localparam int             DEPTH = 4;
  localparam int             ERRW  = 16;
  localparam int             CW    = $clog2(DEPTH + 1);
  localparam logic [NCH-1:0] DUAL  = 8'hF0;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NCH-1:0]     mask;
  logic [NCH-1:0]     undo;
  logic               trig;
  logic               errclr;
  logic [2*NCH-1:0]   bufClr;
  logic [2*NCH-1:0]   blip;
  logic               trigOk;
  logic [CW-1:0]      nFull;
  logic [ERRW-1:0]    nErr;
  logic [NCH-1:0]     errFlags;
`ifdef BUFOCC_PEAK_EN
  logic [CW-1:0]      peakFull;
`endif

  int nVectors = 0;
  int nMiss    = 0;

  // Reference model state: counts per FPGA, start cycle of the frame in flight.
  int               mCnt [NCH][2];
  int               mStart [NCH];
  bit               mB2 [NCH];
  logic [2*NCH-1:0] mBlip;
  logic [NCH-1:0]   mFlags;
  int               mNErr;
  int               cyc = 0;

  buf_occupancy_tracker #(
    .NCH(NCH), .DEPTH(DEPTH), .DUAL_MASK(DUAL), .ERRW(ERRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mask(mask), .undo_buf(undo),
    .trigger(trig), .err_clr(errclr), .buf_clr(bufClr), .blip(blip),
    .trig_ok(trigOk), .n_full(nFull), .n_err(nErr), .err_flags(errFlags)
`ifdef BUFOCC_PEAK_EN
    , .peak_full(peakFull)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pinModel(input string name, input int got, input int exp);
    nVectors++;
    if (got != exp) begin
      nMiss++;
      $display("[TB] FAIL model %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      mCnt[i][0] = 0;
      mCnt[i][1] = 0;
      mStart[i]  = -1;
      mB2[i]     = 1'b0;
    end
    mBlip  = '0;
    mFlags = '0;
    mNErr  = 0;
  endtask

  // One cycle of the rules: frame bit 2 at offset 1, code at offset 2, next start from offset 4.
  task automatic modelStep();
    logic [NCH-1:0]   newErr;
    logic [2*NCH-1:0] nb;
    int               off;
    bit               dec [2];
    bit               err;
    newErr = '0;
    nb     = '0;
    for (int i = 0; i < NCH; i++) begin
      dec[0] = 1'b0;
      dec[1] = 1'b0;
      err    = 1'b0;
      if (!mask[i]) begin
        mCnt[i][0] = 0;
        mCnt[i][1] = 0;
        mStart[i]  = -1;
      end else begin
        off = (mStart[i] < 0) ? 99 : cyc - mStart[i];
        if (off == 1) begin
          mB2[i] = undo[i];
        end else if (off == 2) begin
          if (mB2[i] && !undo[i]) dec[0] = 1'b1;
          else if (DUAL[i] && !mB2[i] && undo[i]) dec[1] = 1'b1;
          else err = 1'b1;
        end else if (off >= 4 && undo[i]) begin
          mStart[i] = cyc;
        end
        for (int f = 0; f < 2; f++) begin
          if (f == 1 && !DUAL[i]) continue;
          if (trig && !dec[f]) begin
            if (mCnt[i][f] == DEPTH) err = 1'b1;
            else mCnt[i][f]++;
          end else if (dec[f] && !trig) begin
            if (mCnt[i][f] == 0) err = 1'b1;
            else mCnt[i][f]--;
          end
        end
        nb[2*i]   = dec[0];
        nb[2*i+1] = DUAL[i] ? dec[1] : dec[0];
        newErr[i] = err;
      end
    end
    mBlip = nb;
    if (errclr) begin
      mFlags = '0;
      mNErr  = 0;
    end else begin
      mFlags = mFlags | newErr;
      if (newErr != '0 && mNErr < (1 << ERRW) - 1) mNErr++;
    end
    cyc++;
  endtask

  task automatic checkOutput();
    logic [2*NCH-1:0] expBuf;
    logic             expTok;
    int               expNf;
    expBuf = '0;
    expTok = 1'b1;
    expNf  = 0;
    for (int i = 0; i < NCH; i++) begin
      expBuf[2*i]   = !mask[i] || mCnt[i][0] < DEPTH;
      expBuf[2*i+1] = DUAL[i] ? (!mask[i] || mCnt[i][1] < DEPTH) : expBuf[2*i];
      if (mask[i]) begin
        for (int f = 0; f < 2; f++) begin
          if (mCnt[i][f] >= DEPTH) expTok = 1'b0;
          if (mCnt[i][f] > expNf) expNf = mCnt[i][f];
        end
      end
    end
    checkEq("buf_clr", 32'(bufClr), 32'(expBuf));
    checkEq("blip", 32'(blip), 32'(mBlip));
    checkEq("trig_ok", 32'(trigOk), 32'(expTok));
    checkEq("n_full", 32'(nFull), 32'(expNf));
    checkEq("n_err", 32'(nErr), 32'(mNErr));
    checkEq("err_flags", 32'(errFlags), 32'(mFlags));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
    checkOutput();
  endtask

  task automatic drive(input logic t, input logic [NCH-1:0] u);
    trig = t;
    undo = u;
    tick();
  endtask

  // Called just after a rising edge; reset is pulsed well clear of the next edge.
  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int trigPct);
    if (cyc % 150 == 0)
      mask = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
    trig   = ($urandom_range(0, 99) < trigPct);
    for (int i = 0; i < NCH; i++) undo[i] = ($urandom_range(0, 9) < 4);
    errclr = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    int trigPct;
    rst_n  = 1'b0;
    mask   = '1;
    undo   = '0;
    trig   = 1'b0;
    errclr = 1'b0;
    modelReset();
    #12;
    checkEq("reset_buf_clr", 32'(bufClr), 32'h0000_FFFF);
    checkEq("reset_trig_ok", 32'(trigOk), 32'd1);
    checkOutput();
    rst_n = 1'b1;

    // Three triggers, then a clear on single board 0.
    repeat (3) drive(1'b1, 8'h00);
    checkEq("s1_n_full", 32'(nFull), 32'd3);
    drive(1'b0, 8'h01);
    drive(1'b0, 8'h01);
    drive(1'b0, 8'h00);
    checkEq("s1_blip", 32'(blip), 32'h0003);
    checkEq("s1_n_err", 32'(nErr), 32'd0);
    pinModel("s1_cnt0", mCnt[0][0], 2);
    drive(1'b0, 8'h00);
    checkEq("s1_blip_gone", 32'(blip), 32'h0000);
    doReset();

    // Fill everything, then clear the odd FPGA of dual board 4.
    repeat (4) drive(1'b1, 8'h00);
    checkEq("s2_buf_clr98", 32'(bufClr[9:8]), 32'd0);
    checkEq("s2_trig_ok", 32'(trigOk), 32'd0);
    checkEq("s2_n_full", 32'(nFull), 32'd4);
    drive(1'b0, 8'h10);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h10);
    checkEq("s2_buf_clr98_odd", 32'(bufClr[9:8]), 32'h2);
    checkEq("s2_blip98", 32'(blip[9:8]), 32'h2);
    drive(1'b0, 8'h00);
    doReset();

    // Overflow on channel 5 alone, then err_clr.
    mask = 8'h20;
    repeat (4) drive(1'b1, 8'h00);
    checkEq("s3_flags_before", 32'(errFlags), 32'd0);
    drive(1'b1, 8'h00);
    checkEq("s3_flags", 32'(errFlags), 32'h20);
    checkEq("s3_n_err", 32'(nErr), 32'd1);
    checkEq("s3_n_full", 32'(nFull), 32'd4);
    errclr = 1'b1;
    drive(1'b0, 8'h00);
    errclr = 1'b0;
    checkEq("s3_flags_clr", 32'(errFlags), 32'd0);
    checkEq("s3_n_err_clr", 32'(nErr), 32'd0);
    mask = '1;
    doReset();

    // Underflow on channel 2, then a bad code on channel 3.
    drive(1'b0, 8'h04);
    drive(1'b0, 8'h04);
    drive(1'b0, 8'h00);
    checkEq("s4_blip", 32'(blip), 32'h0030);
    checkEq("s4_flags", 32'(errFlags), 32'h04);
    checkEq("s4_n_err", 32'(nErr), 32'd1);
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h08);
    drive(1'b0, 8'h08);
    drive(1'b0, 8'h08);
    checkEq("s4_bad_blip", 32'(blip), 32'h0000);
    checkEq("s4_bad_flags", 32'(errFlags), 32'h0C);
    checkEq("s4_bad_n_err", 32'(nErr), 32'd2);
    drive(1'b0, 8'h00);
    doReset();

    // Clear-even on dual board 6 coinciding with a trigger, then mask it off.
    repeat (2) drive(1'b1, 8'h00);
    drive(1'b0, 8'h40);
    drive(1'b0, 8'h40);
    drive(1'b1, 8'h00);
    pinModel("s5_even", mCnt[6][0], 2);
    pinModel("s5_odd", mCnt[6][1], 3);
    checkEq("s5_blip", 32'(blip[13:12]), 32'h1);
    checkEq("s5_n_full", 32'(nFull), 32'd3);
    mask = 8'hBF;
    drive(1'b0, 8'h00);
    checkEq("s5_masked_buf", 32'(bufClr[13:12]), 32'h3);
    pinModel("s5_masked_cnt", mCnt[6][0], 0);
    mask = '1;
    doReset();

    // Reset in the middle of a frame, then a fresh frame decodes from scratch.
    repeat (3) drive(1'b1, 8'h00);
    drive(1'b0, 8'h01);
    drive(1'b0, 8'h01);
    doReset();
    checkEq("s6_n_full", 32'(nFull), 32'd0);
    checkEq("s6_buf_clr", 32'(bufClr), 32'h0000_FFFF);
    drive(1'b0, 8'h01);
    drive(1'b0, 8'h01);
    drive(1'b0, 8'h00);
    checkEq("s6_blip", 32'(blip), 32'h0003);
    checkEq("s6_flags", 32'(errFlags), 32'h01);
    drive(1'b0, 8'h00);

    // Randomized traffic with a trigger rate that changes per segment.
    trigPct = 6;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) trigPct = $urandom_range(2, 14);
      applyStimulus(trigPct);
      tick();
      if ($urandom_range(0, 599) == 0) doReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
